// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle between the RV32I pipeline datapath and hazard_ctrl.
// The datapath side uses the master modport; the controller uses the slave modport.
interface hazard_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [4:0]            Rs1D;
    logic [4:0]            Rs2D;
    logic [4:0]            Rs1E;
    logic [4:0]            Rs2E;
    logic [4:0]            RdE;
    logic [4:0]            RdM;
    logic [4:0]            RdW;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic                  LoadE;
    logic                  PCSrcE;
    logic                  MemReqM;
    logic                  MemReadyM;
    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  StallM;
    logic                  FlushD;
    logic                  FlushE;
    logic                  FlushW;
    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;
    logic                  mem_timeout;
    logic [DATA_WIDTH-1:0] stall_cycles;
    logic [DATA_WIDTH-1:0] flush_events;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, mem_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, mem_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage RV32I hazard controller: forwarding, load-use, branch flush and memory-wait freeze
// with watchdog. Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             mem_timeout_r;

    logic       lw_stall_s;
    logic       br_flush_s;
    logic       mem_stall_s;
    logic       abort_s;
    logic       stall_f_s;
    logic       stall_d_s;
    logic       stall_e_s;
    logic       stall_m_s;
    logic       flush_d_s;
    logic       flush_e_s;
    logic       flush_w_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // M-stage result wins over W; writes to x0 are never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection and memory-wait classification for the current cycle.
    always_comb begin
        lw_stall_s  = bus.LoadE && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
        br_flush_s  = bus.PCSrcE;
        mem_stall_s = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                mem_stall_s = bus.MemReqM && !bus.MemReadyM;
            end
            ST_MEM_WAIT: begin
                mem_stall_s = !bus.MemReadyM && (wait_cnt_r <  TIMEOUT_C);
                abort_s     = !bus.MemReadyM && (wait_cnt_r >= TIMEOUT_C);
            end
            default: begin
                mem_stall_s = 1'b0;
                abort_s     = 1'b0;
            end
        endcase
    end

    // Prioritised stall/flush outputs; everything is quiet while reset is held.
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_w_s = 1'b0;
        fwd_a_s   = 2'b00;
        fwd_b_s   = 2'b00;
        if (rst) begin
            fwd_a_s = 2'b00;
        end else begin
            fwd_a_s = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
            fwd_b_s = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
            if (mem_stall_s) begin
                // Freeze everything; a pending branch stays in E and resolves on release.
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                stall_e_s = 1'b1;
                stall_m_s = 1'b1;
                flush_w_s = 1'b1;
            end else if (abort_s) begin
                flush_w_s = 1'b1;
                flush_d_s = br_flush_s;
                flush_e_s = br_flush_s;
            end else if (br_flush_s) begin
                flush_d_s = 1'b1;
                flush_e_s = 1'b1;
            end else if (lw_stall_s) begin
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                flush_e_s = 1'b1;
            end else begin
                flush_w_s = 1'b0;
            end
        end
    end

    // RUN / MEM_WAIT sequencer with watchdog and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= {CNT_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_stall_s) begin
                        state_r    <= ST_MEM_WAIT;
                        wait_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r    <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.MemReadyM) begin
                        state_r       <= ST_RUN;
                    end else if (abort_s) begin
                        state_r       <= ST_RUN;
                        mem_timeout_r <= 1'b1;
                    end else begin
                        wait_cnt_r    <= wait_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [DATA_WIDTH-1:0] CNT_MAX_C = {DATA_WIDTH{1'b1}};
    logic [DATA_WIDTH-1:0] stall_cnt_r;
    logic [DATA_WIDTH-1:0] flush_cnt_r;

    // Saturating performance counters for fetch stalls and decode flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {DATA_WIDTH{1'b0}};
            flush_cnt_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (stall_f_s && (stall_cnt_r != CNT_MAX_C)) begin
                stall_cnt_r <= stall_cnt_r + DATA_WIDTH'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_d_s && (flush_cnt_r != CNT_MAX_C)) begin
                flush_cnt_r <= flush_cnt_r + DATA_WIDTH'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.stall_cycles = stall_cnt_r;
    assign bus.flush_events = flush_cnt_r;
`else
    assign bus.stall_cycles = {DATA_WIDTH{1'b0}};
    assign bus.flush_events = {DATA_WIDTH{1'b0}};
`endif

    assign bus.StallF      = stall_f_s;
    assign bus.StallD      = stall_d_s;
    assign bus.StallE      = stall_e_s;
    assign bus.StallM      = stall_m_s;
    assign bus.FlushD      = flush_d_s;
    assign bus.FlushE      = flush_e_s;
    assign bus.FlushW      = flush_w_s;
    assign bus.ForwardAE   = fwd_a_s;
    assign bus.ForwardBE   = fwd_b_s;
    assign bus.mem_timeout = mem_timeout_r;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (TIMEOUT=4); counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;
    logic clk;
    logic rst;

    hazard_ctrl_if #(.DATA_WIDTH(32)) bus ();

    hazard_ctrl #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    typedef struct packed {
        logic [6:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        to;
        logic [31:0] sc;
        logic [31:0] fe;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_sc = 32'd0;
    logic [31:0] exp_fe = 32'd0;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LW   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;
    localparam logic [6:0] C_ABT  = 7'b0000001;

    task automatic clr_inputs();
        bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
        bus.RdE = 5'd0;  bus.RdM = 5'd0;  bus.RdW = 5'd0;
        bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.LoadE = 1'b0;
        bus.PCSrcE = 1'b0; bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
    endtask

    task automatic check_out();
        exp_t        e;
        string       t;
        logic [6:0]  ctl;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        ctl = {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE, bus.FlushW};
        checks++;
        assert (ctl === e.ctl) else begin
            errors++; $error("FAIL %s ctl observed=%b expected=%b", t, ctl, e.ctl);
        end
        checks++;
        assert (bus.ForwardAE === e.fa) else begin
            errors++; $error("FAIL %s ForwardAE observed=%b expected=%b", t, bus.ForwardAE, e.fa);
        end
        checks++;
        assert (bus.ForwardBE === e.fb) else begin
            errors++; $error("FAIL %s ForwardBE observed=%b expected=%b", t, bus.ForwardBE, e.fb);
        end
        checks++;
        assert (bus.mem_timeout === e.to) else begin
            errors++; $error("FAIL %s mem_timeout observed=%b expected=%b", t, bus.mem_timeout, e.to);
        end
        checks++;
        assert (bus.stall_cycles === e.sc) else begin
            errors++; $error("FAIL %s stall_cycles observed=%0d expected=%0d", t, bus.stall_cycles, e.sc);
        end
        checks++;
        assert (bus.flush_events === e.fe) else begin
            errors++; $error("FAIL %s flush_events observed=%0d expected=%0d", t, bus.flush_events, e.fe);
        end
    endtask

    // Inputs are already applied; push the expectation, compare mid-cycle, then cross the edge.
    task automatic step(input string tag, input logic [6:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb, input logic to);
        exp_t e;
        e.ctl = ctl; e.fa = fa; e.fb = fb; e.to = to;
`ifdef HAZARD_PERF_EN
        e.sc = exp_sc; e.fe = exp_fe;
        if (rst) begin
            exp_sc = 32'd0; exp_fe = 32'd0;
        end else begin
            if (ctl[6]) exp_sc = exp_sc + 32'd1;
            if (ctl[2]) exp_fe = exp_fe + 32'd1;
        end
`else
        e.sc = 32'd0; e.fe = 32'd0;
`endif
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Hazards present while reset is held must not reach the outputs.
        bus.LoadE = 1'b1; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
        bus.RegWriteM = 1'b1; bus.RdM = 5'd7; bus.Rs1E = 5'd7;
        bus.PCSrcE = 1'b1; bus.MemReqM = 1'b1;
        step("reset_hold", C_NONE, 2'b00, 2'b00, 1'b0);

        rst = 1'b0; clr_inputs();
        step("idle", C_NONE, 2'b00, 2'b00, 1'b0);

        bus.LoadE = 1'b1; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
        step("lw_rs1", C_LW, 2'b00, 2'b00, 1'b0);
        clr_inputs();
        step("lw_release", C_NONE, 2'b00, 2'b00, 1'b0);

        bus.LoadE = 1'b1; bus.RdE = 5'd9; bus.Rs2D = 5'd9; bus.Rs1D = 5'd3;
        step("lw_rs2", C_LW, 2'b00, 2'b00, 1'b0);
        clr_inputs();
        bus.LoadE = 1'b1; bus.RdE = 5'd0; bus.Rs1D = 5'd0; bus.Rs2D = 5'd0;
        step("lw_x0", C_NONE, 2'b00, 2'b00, 1'b0);

        clr_inputs();
        bus.RdM = 5'd7; bus.RdW = 5'd7; bus.RegWriteM = 1'b1; bus.RegWriteW = 1'b1;
        bus.Rs1E = 5'd7; bus.Rs2E = 5'd3;
        step("fwd_m_prio", C_NONE, 2'b10, 2'b00, 1'b0);
        bus.RegWriteM = 1'b0;
        step("fwd_w", C_NONE, 2'b01, 2'b00, 1'b0);
        bus.RdM = 5'd4; bus.RdW = 5'd3; bus.RegWriteM = 1'b1; bus.RegWriteW = 1'b1;
        bus.Rs1E = 5'd3; bus.Rs2E = 5'd4;
        step("fwd_split", C_NONE, 2'b01, 2'b10, 1'b0);
        bus.RdM = 5'd0; bus.RdW = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
        step("fwd_x0", C_NONE, 2'b00, 2'b00, 1'b0);

        clr_inputs();
        bus.PCSrcE = 1'b1; bus.LoadE = 1'b1; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
        step("br_over_lw", C_BR, 2'b00, 2'b00, 1'b0);

        clr_inputs();
        bus.MemReqM = 1'b1; bus.PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_wait", C_MEM, 2'b00, 2'b00, 1'b0);
        bus.MemReadyM = 1'b1;
        step("mem_release", C_BR, 2'b00, 2'b00, 1'b0);
        clr_inputs();
        step("mem_after", C_NONE, 2'b00, 2'b00, 1'b0);

        bus.MemReqM = 1'b1; bus.MemReadyM = 1'b1;
        step("mem_hit", C_NONE, 2'b00, 2'b00, 1'b0);

        bus.MemReadyM = 1'b0;
        for (int i = 0; i < 5; i++) step("tmo_stall", C_MEM, 2'b00, 2'b00, 1'b0);
        step("tmo_abort", C_ABT, 2'b00, 2'b00, 1'b0);
        clr_inputs();
        step("tmo_sticky1", C_NONE, 2'b00, 2'b00, 1'b1);
        step("tmo_sticky2", C_NONE, 2'b00, 2'b00, 1'b1);

        bus.MemReqM = 1'b1;
        step("rstw_enter", C_MEM, 2'b00, 2'b00, 1'b1);
        rst = 1'b1;
        step("rstw_hold", C_NONE, 2'b00, 2'b00, 1'b1);
        rst = 1'b0; clr_inputs();
        step("rstw_run", C_NONE, 2'b00, 2'b00, 1'b0);

        bus.LoadE = 1'b1; bus.RdE = 5'd6; bus.Rs1D = 5'd6;
        step("lw2_a", C_LW, 2'b00, 2'b00, 1'b0);
        bus.RdE = 5'd8; bus.Rs1D = 5'd1; bus.Rs2D = 5'd8;
        step("lw2_b", C_LW, 2'b00, 2'b00, 1'b0);
        clr_inputs();
        step("lw2_count", C_NONE, 2'b00, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RV32I core. It drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers and the E-stage forwarding muxes. It resolves load-use, taken-branch and data-memory wait hazards. A small FSM freezes the whole pipeline while the data memory is not ready, with a watchdog that aborts stuck accesses.

## Interface
Parameters:
- DATA_WIDTH, 32: width of the performance counters.
- TIMEOUT, 255: maximum number of MEM_WAIT cycles before an abort. Must be at least 1.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- Rs1D, Rs2D  in  5  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in E.
- RdM, RdW  in  5  destination registers in M and W.
- RegWriteM, RegWriteW  in  1  register writeback enables in M and W.
- LoadE  in  1  the instruction in E is a load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- MemReqM  in  1  M stage is issuing a data-memory access.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  load a bubble into D/E/W.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = W result, 10 = M ALU result.
- mem_timeout  out  1  sticky error flag.
- stall_cycles, flush_events  out  DATA_WIDTH  performance counters.

## Operation
- **Forwarding (combinational):**
  - ForwardAE = 10 if RegWriteM, RdM≠0 and RdM==Rs1E.
  - Else ForwardAE = 01 if RegWriteW, RdW≠0 and RdW==Rs1E.
  - Else ForwardAE = 00.
  - ForwardBE follows the same rules using Rs2E.
- **Load-use:** lwStall = LoadE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- **Branch:** brFlush = PCSrcE.
- **memStall** is asserted when either of these holds:
  - state RUN with MemReqM & !MemReadyM;
  - state MEM_WAIT with !MemReadyM and wait_cnt<TIMEOUT.
- **Output priority:**
  1. memStall. StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD=FlushE=0. The branch is held in E and re-evaluated after release.
  2. brFlush. FlushD=FlushE=1 and StallF=StallD=0. A concurrent lwStall is discarded because the dependent instruction is flushed.
  3. lwStall. StallF=StallD=1 and FlushE=1.
  4. Otherwise all stall and flush outputs are 0.
- **FSM states:** RUN, MEM_WAIT.
  - RUN→MEM_WAIT when MemReqM & !MemReadyM; wait_cnt←0.
  - MEM_WAIT→RUN when MemReadyM. Stalls drop in that same cycle and the access completes.
  - MEM_WAIT with !MemReadyM and wait_cnt<TIMEOUT: stay; wait_cnt←wait_cnt+1.
  - MEM_WAIT with !MemReadyM and wait_cnt==TIMEOUT (abort cycle): stalls are 0, FlushW=1, next state RUN, mem_timeout←1.
- **mem_timeout** clears only on rst.
- **Counter width:** wait_cnt is $clog2(TIMEOUT+1) bits.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the current state, valid in the same cycle.
- A miss in RUN stalls in that cycle (Mealy), so there is no extra latency before the freeze.
- Total freeze for a response that is ready on the k-th MEM_WAIT cycle: k cycles (1 RUN + k−1 MEM_WAIT).
- Abort occurs after TIMEOUT+1 stall cycles. mem_timeout is visible on the cycle after the abort cycle.
- **Reset:** while rst=1, all stall and flush outputs are 0 and ForwardAE/ForwardBE=00. After the edge:
  - state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0, flush_events=0.
- **rst during MEM_WAIT:** the FSM returns to RUN at the next edge and the pending access is dropped.
- **Register x0:** any match on register 0 never causes forwarding or a load-use stall.

## Configuration
- **HAZARD_PERF_EN defined:**
  - stall_cycles increments on each cycle with StallF=1.
  - flush_events increments on each cycle with FlushD=1.
  - Both saturate at all-ones and both clear on rst.
- **HAZARD_PERF_EN undefined:** both ports are driven constant 0 and no counter flops exist.

## Test plan
- **Load-use stall:** RdE=5, LoadE=1, Rs1D=5.
  - Required: StallF=StallD=FlushE=1 for exactly one cycle.
  - Variant with RdE=0: no stall.
- **Forwarding priority:** RdM=RdW=7, both RegWrite=1, Rs1E=7 → ForwardAE=10. With RegWriteM=0 → ForwardAE=01.
- **Branch beats load-use:** PCSrcE=1 and lwStall true together.
  - Required: FlushD=FlushE=1, StallF=StallD=0.
- **Memory wait:** MemReqM=1, MemReadyM low for 3 cycles, then high.
  - Required: all stalls and FlushW high for 3 cycles, then released.
  - A PCSrcE=1 held throughout produces FlushD only on the release cycle.
- **Timeout:** TIMEOUT=4, MemReadyM held 0.
  - Required: 5 stall cycles, then an abort cycle with stalls low and FlushW=1.
  - mem_timeout=1 afterwards and stays 1 until rst.
- **Reset mid-wait plus counters:** assert rst in MEM_WAIT.
  - Required: state RUN and mem_timeout=0.
  - With HAZARD_PERF_EN, stall_cycles returns to 0 and then counts 2 for a subsequent 2-cycle load-use sequence.
